// File: rtl/hop_chain_array.sv
// Array of independent valid-tagged delay chains with ready/valid backpressure,
// per-channel flush, per-stage clear, rotate mode and per-channel occupancy.
module hop_chain_array #(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned DEPTH    = 6,
    parameter int unsigned WIDTH    = 1,
    localparam int unsigned OCC_W   = $clog2(DEPTH + 1)
) (
    input  logic                      clock0,
    input  logic                      rst1,
    input  logic                      en,
    input  logic                      loop_mode,
    input  logic [CHANNELS-1:0]       start_valid,
    input  logic [CHANNELS*WIDTH-1:0] start_data,
    output logic [CHANNELS-1:0]       start_ready,
    input  logic [CHANNELS-1:0]       flush,
    input  logic [DEPTH-1:0]          stage_clr,
    output logic [CHANNELS-1:0]       out_valid,
    output logic [CHANNELS*WIDTH-1:0] out_data,
    input  logic [CHANNELS-1:0]       out_ready,
    output logic [CHANNELS*OCC_W-1:0] occupancy
);

    logic [CHANNELS-1:0][DEPTH-1:0]            v_q, v_d;
    logic [CHANNELS-1:0][DEPTH-1:0][WIDTH-1:0] d_q, d_d;
    logic [CHANNELS-1:0]                       adv;

    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            adv[c] = en & ~loop_mode & ~rst1 & (~v_q[c][DEPTH-1] | out_ready[c]);
        end
    end

    assign start_ready = adv;

    always_comb begin
        out_valid = '0;
        out_data  = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            out_valid[c]                = v_q[c][DEPTH-1] & en & ~loop_mode;
            out_data[c*WIDTH +: WIDTH]  = d_q[c][DEPTH-1];
        end
    end

    always_comb begin
        occupancy = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            logic [OCC_W-1:0] cnt;
            cnt = '0;
            for (int k = 0; k < DEPTH; k++) begin
                cnt = cnt + OCC_W'(v_q[c][k]);
            end
            occupancy[c*OCC_W +: OCC_W] = cnt;
        end
    end

    // Clears are applied on top of the shift/rotate result, flush last so it wins.
    always_comb begin
        v_d = v_q;
        d_d = d_q;
        for (int c = 0; c < CHANNELS; c++) begin
            if (adv[c]) begin
                v_d[c][0] = start_valid[c];
                if (start_valid[c]) begin
                    d_d[c][0] = start_data[c*WIDTH +: WIDTH];
                end
                for (int k = 1; k < DEPTH; k++) begin
                    v_d[c][k] = v_q[c][k-1];
                    d_d[c][k] = d_q[c][k-1];
                end
            end else if (en && loop_mode) begin
                v_d[c][0] = v_q[c][DEPTH-1];
                d_d[c][0] = d_q[c][DEPTH-1];
                for (int k = 1; k < DEPTH; k++) begin
                    v_d[c][k] = v_q[c][k-1];
                    d_d[c][k] = d_q[c][k-1];
                end
            end
            for (int k = 0; k < DEPTH; k++) begin
                if (stage_clr[k]) begin
                    v_d[c][k] = 1'b0;
                    d_d[c][k] = '0;
                end
            end
            if (flush[c]) begin
                v_d[c] = '0;
                d_d[c] = '0;
            end
        end
    end

    always_ff @(posedge clock0) begin
        if (rst1) begin
            v_q <= '0;
            d_q <= '0;
        end else begin
            v_q <= v_d;
            d_q <= d_d;
        end
    end

endmodule

// File: tb/tb_hop_chain_array.sv
// Directed bench for hop_chain_array with default parameters (4 channels, 6 stages, 1 bit).
module tb_hop_chain_array;

    localparam int CH = 4;
    localparam int DP = 6;
    localparam int OW = 3;

    logic            clock0 = 1'b0;
    logic            rst1;
    logic            en;
    logic            loop_mode;
    logic [CH-1:0]   start_valid;
    logic [CH-1:0]   start_data;
    logic [CH-1:0]   start_ready;
    logic [CH-1:0]   flush;
    logic [DP-1:0]   stage_clr;
    logic [CH-1:0]   out_valid;
    logic [CH-1:0]   out_data;
    logic [CH-1:0]   out_ready;
    logic [CH*OW-1:0] occupancy;

    int total = 0;
    int bad   = 0;

    hop_chain_array dut (
        .clock0      (clock0),
        .rst1        (rst1),
        .en          (en),
        .loop_mode   (loop_mode),
        .start_valid (start_valid),
        .start_data  (start_data),
        .start_ready (start_ready),
        .flush       (flush),
        .stage_clr   (stage_clr),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_ready   (out_ready),
        .occupancy   (occupancy)
    );

    always #5 clock0 = ~clock0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock0);
        #1;
    endtask

    function automatic logic [31:0] occ(input int c);
        return 32'(occupancy[c*OW +: OW]);
    endfunction

    initial begin
        rst1 = 1'b1; en = 1'b1; loop_mode = 1'b0;
        start_valid = '0; start_data = '0; flush = '0; stage_clr = '0;
        out_ready = '1;

        // Reset
        tick(); tick();
        check("rst_ready", 32'(start_ready), 0);
        check("rst_ovalid", 32'(out_valid), 0);
        check("rst_odata", 32'(out_data), 0);
        check("rst_occ", 32'(occupancy), 0);
        rst1 = 1'b0;
        #1;
        check("idle_ready", 32'(start_ready), 32'hF);

        // Single word through channel 0
        start_valid = 4'b0001; start_data = 4'b0001;
        tick();
        start_valid = '0; start_data = '0;
        for (int i = 0; i <= 6; i++) begin
            check($sformatf("lat_ov_%0d", i), 32'(out_valid[0]), (i == 5) ? 1 : 0);
            check($sformatf("lat_occ_%0d", i), occ(0), (i == 6) ? 0 : 1);
            if (i == 5) check("lat_od", 32'(out_data[0]), 1);
            tick();
        end

        // Channel 1 fills and stalls, channel 2 keeps flowing
        out_ready = 4'b1101;
        for (int i = 0; i < 6; i++) begin
            start_valid = 4'b0110;
            start_data  = {1'b0, 1'b1, (i % 2 == 0) ? 1'b1 : 1'b0, 1'b0};
            tick();
        end
        check("stall_ready1", 32'(start_ready[1]), 0);
        check("stall_occ1", occ(1), 6);
        check("flow_ready2", 32'(start_ready[2]), 1);
        check("flow_ov2", 32'(out_valid[2]), 1);
        tick();
        check("stall_hold_occ1", occ(1), 6);
        check("flow_occ2", occ(2), 6);
        start_valid = '0; start_data = '0;
        out_ready = 4'b1111;
        #1;
        for (int j = 0; j < 6; j++) begin
            check($sformatf("drain_ov_%0d", j), 32'(out_valid[1]), 1);
            check($sformatf("drain_od_%0d", j), 32'(out_data[1]), (j % 2 == 0) ? 1 : 0);
            tick();
        end
        check("drain_occ1", occ(1), 0);
        check("drain_occ2", occ(2), 0);

        // Load channel 3 so stage 0 holds 1 and stages 1..5 hold 0, then rotate
        out_ready = 4'b0111;
        for (int i = 0; i < 6; i++) begin
            start_valid = 4'b1000;
            start_data  = (i == 5) ? 4'b1000 : 4'b0000;
            tick();
        end
        start_valid = '0; start_data = '0;
        loop_mode = 1'b1;
        #1;
        for (int t = 1; t <= 6; t++) begin
            tick();
            check($sformatf("loop_ov_%0d", t), 32'(out_valid), 0);
            check($sformatf("loop_rdy_%0d", t), 32'(start_ready), 0);
            check($sformatf("loop_od_%0d", t), 32'(out_data[3]), (t == 5) ? 1 : 0);
            check($sformatf("loop_occ_%0d", t), occ(3), 6);
        end
        loop_mode = 1'b0;
        #1;
        check("loop_after_ov", 32'(out_valid[3]), 1);
        check("loop_after_od", 32'(out_data[3]), 0);

        // Fill every channel, then punch a hole in stage 2
        out_ready = '0;
        start_valid = 4'b0111; start_data = 4'b0111;
        for (int i = 0; i < 6; i++) tick();
        start_valid = '0; start_data = '0;
        for (int c = 0; c < CH; c++) check($sformatf("full_occ%0d", c), occ(c), 6);
        stage_clr = 6'b000100;
        tick();
        stage_clr = '0;
        for (int c = 0; c < CH; c++) check($sformatf("clr_occ%0d", c), occ(c), 5);
        out_ready = '1;
        #1;
        for (int t = 0; t <= 4; t++) begin
            check($sformatf("bubble_ov_%0d", t), 32'(out_valid), (t == 3) ? 0 : 32'hF);
            tick();
        end
        for (int i = 0; i < 6; i++) tick();
        check("empty_occ", 32'(occupancy), 0);

        // Flush channel 0 on the same edge it accepts a word
        start_valid = 4'b0011; start_data = 4'b0011; flush = 4'b0001;
        tick();
        start_valid = '0; start_data = '0; flush = '0;
        check("flush_occ0", occ(0), 0);
        check("flush_occ1", occ(1), 1);
        for (int t = 1; t <= 6; t++) begin
            tick();
            check($sformatf("flush_ov0_%0d", t), 32'(out_valid[0]), 0);
            check($sformatf("flush_ov1_%0d", t), 32'(out_valid[1]), (t == 5) ? 1 : 0);
        end

        // Mid-operation reset
        start_valid = '1; start_data = '1;
        for (int i = 0; i < 3; i++) tick();
        for (int c = 0; c < CH; c++) check($sformatf("half_occ%0d", c), occ(c), 3);
        rst1 = 1'b1;
        #1;
        check("rst_held_ready", 32'(start_ready), 0);
        tick();
        check("mrst_occ", 32'(occupancy), 0);
        check("mrst_ov", 32'(out_valid), 0);
        check("mrst_ready", 32'(start_ready), 0);
        rst1 = 1'b0; start_valid = '0; start_data = '0;
        #1;
        check("mrst_release_ready", 32'(start_ready), 32'hF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hop_chain_array.md
Name: hop_chain_array

Overview:
- Parametrised successor to the fixed four-chain, six-hop flop benchmark.
- CHANNELS independent pipelines, each DEPTH stages deep and WIDTH bits wide, each stage carrying a valid bit.
- Adds ready/valid backpressure, per-channel flush, per-stage clear (the generalised form of per-flop resets), a loop/rotate mode and per-channel occupancy.
- Serves as a hop-count/routing stress block in the micro-benchmark suite and as a reusable delay-line primitive.

Parameters:
- CHANNELS, 4, number of independent chains.
- DEPTH, 6, stages per chain (>=2).
- WIDTH, 1, data bits per stage.
- OCC_W, $clog2(DEPTH+1), occupancy field width (derived, not overridden).

Ports:
- clock0  in  1  sole clock, rising edge.
- rst1  in  1  synchronous, active-high reset.
- en  in  1  global advance enable.
- loop_mode  in  1  1 = all chains rotate internally; 0 = normal shift.
- start_valid  in  CHANNELS  per-channel input valid.
- start_data  in  CHANNELS*WIDTH  input data; channel c at bits [c*WIDTH +: WIDTH].
- start_ready  out  CHANNELS  per-channel input ready.
- flush  in  CHANNELS  per-channel clear of all stages.
- stage_clr  in  DEPTH  clears stage k in every channel.
- out_valid  out  CHANNELS  last-stage valid (gated).
- out_data  out  CHANNELS*WIDTH  last-stage data.
- out_ready  in  CHANNELS  downstream ready.
- occupancy  out  CHANNELS*OCC_W  count of valid stages per channel.

Behaviour:
- **State per channel c, stage k:** v[c][k] and d[c][k]. Stage 0 is the input end; stage DEPTH-1 drives the output.
- **Reset:** when rst1=1 at an edge, all v and d are set to 0. All other inputs are ignored that cycle.
- **Reset values:** out_valid=0, out_data=0, occupancy=0. start_ready=0 while rst1 is held, because start_ready is gated by ~rst1.
- **Advance condition (combinational):** adv[c] = en & ~loop_mode & ~rst1 & (~v[c][DEPTH-1] | out_ready[c]).
- **Handshake outputs:**
  - start_ready[c] = adv[c].
  - out_valid[c] = v[c][DEPTH-1] & en & ~loop_mode.
  - out_data[c] = d[c][DEPTH-1] (ungated).
  - An input transfer occurs on start_valid & start_ready. An output transfer occurs on out_valid & out_ready.
- **Shift (adv[c]=1):**
  - v[c][0] <= start_valid[c]; d[c][0] <= start_data[c] when start_valid, else holds.
  - For k>=1: v[c][k] <= v[c][k-1] and d[c][k] <= d[c][k-1].
  - Bubbles travel with the chain and are not collapsed.
- **Stall (en=1, loop_mode=0, v[c][DEPTH-1]=1, out_ready[c]=0):** the whole channel holds. Input is not accepted. Data offered while stalled must be held by the source.
- **Loop mode (en=1, loop_mode=1):**
  - Every channel rotates: stage 0 <= stage DEPTH-1, and stage k <= stage k-1 for both v and d.
  - out_valid=0 and start_ready=0. Nothing is lost and nothing enters.
- **en=0:** all state holds; out_valid=0; start_ready=0.
- **Latency:** a word accepted at edge N is presented on out_valid/out_data after edge N+DEPTH-1, provided no stall occurs. This gives DEPTH registers in the path, which is 6 by default and matches the legacy chain.
- **Clears (applied after the shift/rotate result at the same edge):**
  - flush[c]=1 sets all v[c][*]=0 and d[c][*]=0, overriding any transfer in that cycle. An accepted input is discarded, and the source sees the transfer as completed.
  - stage_clr[k]=1 sets v[*][k]=0 and d[*][k]=0 in all channels, overriding whatever would have been shifted or rotated into stage k.
  - Priority: rst1 > flush > stage_clr > shift/rotate/hold.
- **Occupancy:** occupancy[c] = popcount of v[c][*]. It is combinational from the registers, with no added latency. Range is 0..DEPTH, and DEPTH must be representable in OCC_W.
- **Channel independence:** a stall, flush or backpressure on one channel never affects another. Only en, loop_mode, stage_clr and rst1 are shared.
- **Mid-operation reset:** contents are lost immediately; there is no drain.

Test Plan:
- Defaults; rst1=1 for 2 cycles then 0; en=1, out_ready=all 1; start_valid[0]=1 with start_data[0]=1 for one cycle, other channels idle -> out_valid[0]=1 exactly DEPTH-1=5 cycles after the accepting edge, for one cycle; occupancy[0] goes 1,1,1,1,1,1,0.
- Fill channel 1 with 6 words alternating 1,0; hold out_ready[1]=0 -> start_ready[1]=0 once stage 5 is valid; occupancy[1]=6; channel 2 keeps flowing. Release out_ready -> the 6 words exit in order 1,0,1,0,1,0.
- Load channel 3 with pattern v=all 1 and d=1,0,0,0,0,0 (stage 0 first), then loop_mode=1 for 6 cycles -> out_valid=0 throughout; after 6 edges the pattern is identical; occupancy stays 6.
- Full channels, pulse stage_clr=6'b000100 for one cycle -> stage 2 invalid in all channels; occupancy=5 each; the bubble exits 3 cycles later as out_valid=0 for one cycle.
- flush[0] asserted in the same cycle as a start_valid[0] transfer -> channel 0 is empty next cycle (occupancy=0) and that word never appears; other channels are unaffected.
- Assert rst1 while channels are half full and en=1 -> next cycle all occupancy=0 and out_valid=0; start_ready=0 while rst1 is held.
